// File: rtl/riscado_pkg.sv
// Shared definitions for the arRISCado core: datapath width, the canonical
// NOP encoding and the fetch-stage state encoding.
package riscado_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    // Byte address to rom word index; the top two bits come out as zero.
    function automatic logic [XLEN-1:0] word_index(input logic [XLEN-1:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: rom port, downstream control and the IF/ID outputs.
// FETCH_MISALIGN_TRAP_EN adds the fetch_misaligned flag.
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] rom_address;
    logic [XLEN-1:0] rom_data;
    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic            halt_req;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic            if_valid;
    logic            halted;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            fetch_misaligned;

    modport master (
        output rom_address, if_instr, if_pc, if_valid, halted, fetch_misaligned,
        input  rom_data, stall, redirect, redirect_target, halt_req
    );
    modport slave (
        input  rom_address, if_instr, if_pc, if_valid, halted, fetch_misaligned,
        output rom_data, stall, redirect, redirect_target, halt_req
    );
`else
    modport master (
        output rom_address, if_instr, if_pc, if_valid, halted,
        input  rom_data, stall, redirect, redirect_target, halt_req
    );
    modport slave (
        input  rom_address, if_instr, if_pc, if_valid, halted,
        output rom_data, stall, redirect, redirect_target, halt_req
    );
`endif
endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter with its next-pc selection: redirect target (word
// aligned), sequential pc+4 (wrapping modulo 2^XLEN) or hold.
module pc_reg #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_target,
    input  logic            advance,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_value_reg;
    logic [XLEN-1:0] pc_next;

    // Next-pc mux; a load always wins over a sequential advance.
    always_comb begin
        pc_next = pc_value_reg;
        if (load_target) begin
            pc_next = target & ~XLEN'(3);
        end else if (advance) begin
            pc_next = pc_value_reg + XLEN'(4);
        end
    end

    // PC register, reloaded with the boot address on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_value_reg <= RESET_PC;
        end else begin
            pc_value_reg <= pc_next;
        end
    end

    assign pc = pc_value_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the pc, addresses the rom and registers the
// returned word into IF/ID. Handles redirect, stall and halt.
// Optional macro FETCH_MISALIGN_TRAP_EN: a redirect to a non word-aligned
// target halts the stage and raises fetch_misaligned instead of clearing
// the low bits.
module fetch_stage
    import riscado_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    fetch_state_e    state_reg;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] if_instr_reg;
    logic [XLEN-1:0] if_pc_reg;
    logic            if_valid_reg;
    logic            halted_reg;
    logic            in_run;
    logic            misaligned_redirect;
    logic            pc_load;
    logic            pc_advance;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            fetch_misaligned_reg;
`endif

    // Decode the downstream controls; they only act while running.
    always_comb begin
        in_run = (state_reg == RUN);
`ifdef FETCH_MISALIGN_TRAP_EN
        misaligned_redirect = (bus.redirect_target[1:0] != 2'b00);
`else
        misaligned_redirect = 1'b0;
`endif
        pc_load    = in_run && bus.redirect && !misaligned_redirect;
        pc_advance = in_run && !bus.redirect && !bus.stall && !bus.halt_req;
    end

    pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .reset       (reset),
        .load_target (pc_load),
        .advance     (pc_advance),
        .target      (bus.redirect_target),
        .pc          (pc)
    );

    // Fetch FSM and IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= BOOT;
            if_instr_reg <= NOP_INSTR;
            if_pc_reg    <= '0;
            if_valid_reg <= 1'b0;
            halted_reg   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fetch_misaligned_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                BOOT: begin
                    state_reg <= RUN;
                end
                RUN: begin
                    if (bus.redirect) begin
                        // Squash the wrong-path word; IF/ID data is left as is.
                        if_valid_reg <= 1'b0;
                        if (misaligned_redirect) begin
                            state_reg  <= HALT;
                            halted_reg <= 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                            fetch_misaligned_reg <= 1'b1;
`endif
                        end
                    end else if (bus.stall) begin
                        state_reg <= RUN;
                    end else if (bus.halt_req) begin
                        state_reg    <= HALT;
                        if_valid_reg <= 1'b0;
                        halted_reg   <= 1'b1;
                    end else begin
                        if_instr_reg <= bus.rom_data;
                        if_pc_reg    <= pc;
                        if_valid_reg <= 1'b1;
                    end
                end
                HALT: begin
                    state_reg    <= HALT;
                    if_valid_reg <= 1'b0;
                    halted_reg   <= 1'b1;
                end
                default: begin
                    state_reg <= BOOT;
                end
            endcase
        end
    end

    assign bus.rom_address = word_index(pc);
    assign bus.if_instr    = if_instr_reg;
    assign bus.if_pc       = if_pc_reg;
    assign bus.if_valid    = if_valid_reg;
    assign bus.halted      = halted_reg;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.fetch_misaligned = fetch_misaligned_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a directed walk through the fetch,
// stall, redirect and halt scenarios, then randomized control traffic, all
// compared against a transaction-level reference model. A second instance
// boots from 32'hFFFF_FFFC to exercise pc wrap-around.
// Honours FETCH_MISALIGN_TRAP_EN like the design.
module tb_fetch_stage;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] HIGH_PC = 32'hFFFF_FFFC;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ipc;
        bit          valid;
        bit          halted;
        bit          booting;
        bit          mis;
    } model_t;

    logic        clk;
    logic        reset;
    logic [31:0] rom_mem [64];
    model_t      m1;
    model_t      m2;
    int          checks;
    int          errors;

    fetch_stage_if #(.XLEN(32)) fif ();
    fetch_stage_if #(.XLEN(32)) fif2 ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (fif.master)
    );

    fetch_stage #(.RESET_PC(HIGH_PC)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (fif2.master)
    );

    assign fif.rom_data  = rom_mem[fif.rom_address[5:0]];
    assign fif2.rom_data = rom_mem[fif2.rom_address[5:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock of the fetch stage described from its rules.
    function automatic model_t model_next(input model_t m, input bit rst, input bit rd,
                                          input logic [31:0] tgt, input bit st, input bit hr,
                                          input logic [31:0] rst_pc);
        model_t n = m;
        if (rst) begin
            n.pc = rst_pc; n.instr = NOP; n.ipc = 0; n.valid = 0;
            n.halted = 0; n.booting = 1; n.mis = 0;
        end else if (m.booting) begin
            n.booting = 0;
        end else if (m.halted) begin
            n.valid = 0;
        end else if (rd) begin
            n.valid = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (tgt % 4 != 0) begin
                n.halted = 1;
                n.mis = 1;
            end else begin
                n.pc = tgt;
            end
`else
            n.pc = tgt - (tgt % 4);
`endif
        end else if (st) begin
            n.valid = m.valid;
        end else if (hr) begin
            n.halted = 1;
            n.valid = 0;
        end else begin
            n.instr = rom_mem[(m.pc / 4) % 64];
            n.ipc = m.pc;
            n.valid = 1;
            n.pc = m.pc + 4;
        end
        return n;
    endfunction

    task automatic compare_all();
        check("rom_address", fif.rom_address, m1.pc / 4);
        check("if_instr", fif.if_instr, m1.instr);
        check("if_pc", fif.if_pc, m1.ipc);
        check("if_valid", {31'd0, fif.if_valid}, {31'd0, m1.valid});
        check("halted", {31'd0, fif.halted}, {31'd0, m1.halted});
`ifdef FETCH_MISALIGN_TRAP_EN
        check("fetch_misaligned", {31'd0, fif.fetch_misaligned}, {31'd0, m1.mis});
`endif
        check("wrap_rom_address", fif2.rom_address, m2.pc / 4);
        check("wrap_if_instr", fif2.if_instr, m2.instr);
        check("wrap_if_pc", fif2.if_pc, m2.ipc);
        check("wrap_if_valid", {31'd0, fif2.if_valid}, {31'd0, m2.valid});
    endtask

    // Apply one cycle of inputs at the falling edge, clock it, compare.
    task automatic step(input bit rst, input bit rd, input logic [31:0] tgt,
                        input bit st, input bit hr);
        reset               = rst;
        fif.redirect        = rd;
        fif.redirect_target = tgt;
        fif.stall           = st;
        fif.halt_req        = hr;
        m1 = model_next(m1, rst, rd, tgt, st, hr, 32'h0);
        m2 = model_next(m2, rst, 1'b0, 32'h0, 1'b0, 1'b0, HIGH_PC);
        @(posedge clk);
        @(negedge clk);
        $display("t=%0t rst=%0d rd=%0d tgt=%h st=%0d hr=%0d -> valid=%0d pc=%h instr=%h halted=%0d",
                 $time, rst, rd, tgt, st, hr, fif.if_valid, fif.if_pc, fif.if_instr, fif.halted);
        compare_all();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) rom_mem[i] = $urandom;
        m1 = '{default: 0};
        m2 = '{default: 0};
        reset = 1'b1;
        fif.stall = 0; fif.redirect = 0; fif.redirect_target = 0; fif.halt_req = 0;
        fif2.stall = 0; fif2.redirect = 0; fif2.redirect_target = 0; fif2.halt_req = 0;
        @(negedge clk);

        // Reset state and boot cycle.
        step(1, 0, 0, 0, 0);
        check("rst_instr", fif.if_instr, NOP);
        check("rst_valid", {31'd0, fif.if_valid}, 32'd0);
        step(0, 0, 0, 0, 0);
        check("boot_valid", {31'd0, fif.if_valid}, 32'd0);

        // Sequential fetch; the wrap instance crosses FFFF_FFFC -> 0.
        step(0, 0, 0, 0, 0);
        check("fetch0_pc", fif.if_pc, 32'h0);
        check("fetch0_instr", fif.if_instr, rom_mem[0]);
        check("wrap_first_pc", fif2.if_pc, HIGH_PC);
        step(0, 0, 0, 0, 0);
        check("wrap_second_pc", fif2.if_pc, 32'h0);
        step(0, 0, 0, 0, 0);
        check("fetch2_pc", fif.if_pc, 32'h8);

        // Stall for three cycles at if_pc=8.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 0);
            check("stall_pc", fif.if_pc, 32'h8);
            check("stall_rom_addr", fif.rom_address, 32'h3);
        end
        step(0, 0, 0, 0, 0);
        check("after_stall_pc", fif.if_pc, 32'hC);

        // Redirect alone, then redirect while stalled.
        step(0, 1, 32'h10, 0, 0);
        check("redir_squash", {31'd0, fif.if_valid}, 32'd0);
        step(0, 0, 0, 0, 0);
        check("redir_pc", fif.if_pc, 32'h10);
        check("redir_instr", fif.if_instr, rom_mem[4]);
        step(0, 1, 32'h10, 1, 0);
        step(0, 0, 0, 0, 0);
        check("redir_stall_pc", fif.if_pc, 32'h10);

        // Misaligned redirect target.
        step(0, 1, 32'h16, 0, 0);
        step(0, 0, 0, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_flag", {31'd0, fif.fetch_misaligned}, 32'd1);
        check("mis_halted", {31'd0, fif.halted}, 32'd1);
`else
        check("misalign_pc", fif.if_pc, 32'h14);
`endif

        // Halt is permanent until reset.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("halt_flag", {31'd0, fif.halted}, 32'd1);
        step(0, 1, 32'h20, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        check("halt_sticky_valid", {31'd0, fif.if_valid}, 32'd0);
        step(1, 0, 0, 0, 0);
        check("rst_after_halt", {31'd0, fif.halted}, 32'd0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("restart_pc", fif.if_pc, 32'h0);

        // Randomized control traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) < 4), ($urandom_range(99) < 12),
                 $urandom_range(255), ($urandom_range(99) < 20),
                 ($urandom_range(99) < 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage of the arRISCado core. It sits directly upstream of the instruction rom. It owns the program counter and drives the rom address. It captures the combinational rom data into the IF/ID pipeline register. It also handles stall, branch/jump redirect and halt from downstream.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset
XLEN, 32, width of PC, instruction and rom address

Ports:
clk  in  1  core clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
rom_address  out  XLEN  word index to rom = {2'b00, pc[XLEN-1:2]}, combinational from pc
rom_data  in  XLEN  instruction word from rom, combinational from rom_address
stall  in  1  hold pc and IF/ID register unchanged
redirect  in  1  branch/jump taken in a later stage
redirect_target  in  XLEN  byte address to fetch next when redirect=1
halt_req  in  1  stop fetching permanently until reset
if_instr  out  XLEN  registered instruction
if_pc  out  XLEN  registered byte PC of if_instr
if_valid  out  1  if_instr/if_pc hold a real instruction
halted  out  1  fetch stopped

Behaviour:
- Reset (reset=1 at edge): pc<=RESET_PC; if_instr<=32'h0000_0013 (NOP); if_pc<=0; if_valid<=0; halted<=0; state<=BOOT.
- States:
  - BOOT: one cycle; outputs stay invalid and pc is unchanged. Next state is RUN unless reset is asserted.
  - RUN: normal fetch.
  - HALT: terminal until reset.
- RUN, priority redirect > stall > halt_req > normal.
- redirect=1: pc<=redirect_target with bits[1:0] forced to 00. if_valid<=0, which squashes the wrong-path word. if_instr and if_pc are not updated. This applies even when stall=1.
- stall=1 (no redirect): pc, if_instr, if_pc and if_valid all hold.
- halt_req=1 (no redirect, no stall): state<=HALT, if_valid<=0, halted<=1, pc holds.
- Normal: if_instr<=rom_data, if_pc<=pc, if_valid<=1, pc<=pc+4. The addition is modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0.
- Fetch-to-output latency is 1 cycle. Sustained throughput is 1 instruction per cycle.
- HALT: all inputs except reset are ignored. if_valid=0 and halted=1.
- BOOT: redirect, stall and halt_req are ignored.
- Reset mid-operation, in any state: behaves as the power-on reset above. Any in-flight redirect is discarded.
- rom_address must never glitch on stall; it is derived only from the pc register.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output fetch_misaligned (1 bit, registered, reset 0).
  - A redirect whose target has target[1:0]!=0 sets fetch_misaligned=1 and forces state to HALT with halted=1. pc is not loaded.
  - fetch_misaligned stays set until reset.
- Undefined: the port is absent. Low bits are silently cleared as described in Behaviour.

Decomposition:
- Shared package riscado_pkg holds:
  - XLEN
  - NOP_INSTR = 32'h0000_0013
  - fetch state encoding BOOT=2'd0, RUN=2'd1, HALT=2'd2
- One natural sub-module: pc_reg. It holds the pc register plus the next-pc mux (pc+4 / target / hold) with reset to RESET_PC.
- fetch_stage instantiates pc_reg and holds the FSM and the IF/ID register.

Test Plan:
- Reset release, connected to rom preloaded with words W0..W5 → cycle 1 in BOOT with if_valid=0. Then successive cycles give if_pc=0,4,8,12 with if_instr=W0..W3, and rom_address=0,1,2,3...
- stall held 3 cycles at if_pc=8 → if_instr, if_pc=8 and rom_address=3 are constant. The cycle after release gives if_pc=12.
- redirect=1, target=0x10, while pc=0x0C → next cycle if_valid=0. Following cycle gives if_pc=0x10 with if_instr=W4. Repeat with stall=1 at the same time: the redirect still applies.
- redirect target 0x16 → without the macro, next fetch has if_pc=0x14. With FETCH_MISALIGN_TRAP_EN: fetch_misaligned=1, halted=1, if_valid=0.
- halt_req for 1 cycle → halted=1 and if_valid=0 permanently. Later redirect or stall has no effect. reset then restarts at RESET_PC.
- RESET_PC=32'hFFFF_FFFC → first valid fetch has if_pc=FFFF_FFFC. The next has if_pc=0 (wrap). Also assert reset mid-run and check outputs return to their reset values one edge later.
